// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALU-op codes,
// FSM state codes and datapath mux selects.
package mips_ctrl_pkg;

   localparam logic [5:0] R_TYPE = 6'h00;
   localparam logic [5:0] J      = 6'h02;
   localparam logic [5:0] BEQ    = 6'h04;
   localparam logic [5:0] BNE    = 6'h05;
   localparam logic [5:0] ADDI   = 6'h08;
   localparam logic [5:0] ANDI   = 6'h0c;
   localparam logic [5:0] ORI    = 6'h0d;
   localparam logic [5:0] LUI    = 6'h0f;
   localparam logic [5:0] LW     = 6'h23;
   localparam logic [5:0] SW     = 6'h2b;

   localparam logic [2:0] ALU_LUI   = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_ADD   = 3'b100;
   localparam logic [2:0] ALU_ADDR  = 3'b101;
   localparam logic [2:0] ALU_SUB   = 3'b110;
   localparam logic [2:0] ALU_FUNCT = 3'b111;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEM_ADDR = 4'd3,
      ST_MEM_RD   = 4'd4,
      ST_MEM_WB   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_EXEC_R   = 4'd7,
      ST_WB_R     = 4'd8,
      ST_EXEC_I   = 4'd9,
      ST_WB_I     = 4'd10,
      ST_BRANCH   = 4'd11,
      ST_JUMP     = 4'd12,
      ST_FAULT    = 4'd13
   } state_t;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] SRC_B_RT      = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   // Instruction-class dispatch out of DECODE; unknown opcodes trap.
   function automatic state_t decode_next(input logic [5:0] op);
      state_t nxt;
      case (op)
         R_TYPE:               nxt = ST_EXEC_R;
         ADDI, LUI, ORI, ANDI: nxt = ST_EXEC_I;
         LW, SW:               nxt = ST_MEM_ADDR;
         BEQ, BNE:             nxt = ST_BRANCH;
         J:                    nxt = ST_JUMP;
         default:              nxt = ST_FAULT;
      endcase
      return nxt;
   endfunction

   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      logic [2:0] code;
      case (op)
         LUI:     code = ALU_LUI;
         ORI:     code = ALU_OR;
         ANDI:    code = ALU_AND;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle
// in which the wait budget is exhausted.
module mem_wait_timer
   import mips_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ready,
   output logic expired
);

   localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             waiting;

   // The counter stops at LIMIT so it never wraps on the cycle that expires.
   always_comb begin
      waiting = active & ~ready;
      expired = 1'b0;
      count_d = '0;
      if (WAIT_LIMIT > 0 && waiting) begin
         if (count_q == LIMIT) begin
            expired = 1'b1;
            count_d = count_q;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with memory, and traps illegal opcodes or stalled accesses.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int ALU_OP_WIDTH = 3,
   parameter int WAIT_LIMIT   = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [5:0]              opcode_i,
   input  logic                    zero_i,
   input  logic                    mem_ready_i,
   output logic                    pc_write_o,
   output logic [1:0]              pc_src_o,
   output logic                    i_or_d_o,
   output logic                    ir_write_o,
   output logic                    mem_read_o,
   output logic                    mem_write_o,
   output logic                    mem_to_reg_o,
   output logic                    reg_dst_o,
   output logic                    reg_write_o,
   output logic                    alu_src_a_o,
   output logic [1:0]              alu_src_b_o,
   output logic [ALU_OP_WIDTH-1:0] alu_op_o,
   output logic [3:0]              state_o,
   output logic                    fault_o
);

   generate
      if (ALU_OP_WIDTH < 3) begin : g_bad_alu_op_width
         $error("multicycle_control: ALU_OP_WIDTH must be at least 3");
      end
   endgenerate

   state_t     state_q;
   state_t     state_d;
   logic       mem_active;
   logic       wait_expired;
   logic [2:0] alu_code;

   assign mem_active = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                       (state_q == ST_MEM_WR);

   mem_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .active  (mem_active),
      .ready   (mem_ready_i),
      .expired (wait_expired)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready_i)       state_d = ST_DECODE;
            else if (wait_expired) state_d = ST_FAULT;
         end
         ST_DECODE:   state_d = decode_next(opcode_i);
         ST_MEM_ADDR: state_d = (opcode_i == SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD: begin
            if (mem_ready_i)       state_d = ST_MEM_WB;
            else if (wait_expired) state_d = ST_FAULT;
         end
         ST_MEM_WR: begin
            if (mem_ready_i)       state_d = ST_FETCH;
            else if (wait_expired) state_d = ST_FAULT;
         end
         ST_MEM_WB:   state_d = ST_FETCH;
         ST_EXEC_R:   state_d = ST_WB_R;
         ST_WB_R:     state_d = ST_FETCH;
         ST_EXEC_I:   state_d = ST_WB_I;
         ST_WB_I:     state_d = ST_FETCH;
         ST_BRANCH:   state_d = ST_FETCH;
         ST_JUMP:     state_d = ST_FETCH;
         ST_FAULT:    state_d = ST_FAULT;
         default:     state_d = ST_FAULT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath controls are a pure decode of the current state, so an
   // asynchronous reset drops every strobe without waiting for a clock edge.
   always_comb begin
      pc_write_o   = 1'b0;
      pc_src_o     = PC_SRC_ALU;
      i_or_d_o     = 1'b0;
      ir_write_o   = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_dst_o    = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRC_B_RT;
      alu_code     = 3'b000;
      fault_o      = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRC_B_FOUR;
            alu_code    = ALU_ADD;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         ST_DECODE: begin
            alu_src_b_o = SRC_B_IMM_SH2;
            alu_code    = ALU_ADD;
         end
         ST_EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRC_B_RT;
            alu_code    = ALU_FUNCT;
         end
         ST_WB_R: begin
            reg_dst_o   = 1'b1;
            reg_write_o = 1'b1;
         end
         ST_EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRC_B_IMM;
            alu_code    = imm_alu_op(opcode_i);
         end
         ST_WB_I: begin
            reg_write_o = 1'b1;
         end
         ST_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRC_B_IMM;
            alu_code    = ALU_ADDR;
         end
         ST_MEM_RD: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
         end
         ST_MEM_WB: begin
            mem_to_reg_o = 1'b1;
            reg_write_o  = 1'b1;
         end
         ST_MEM_WR: begin
            mem_write_o = 1'b1;
            i_or_d_o    = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRC_B_RT;
            alu_code    = ALU_SUB;
            pc_src_o    = PC_SRC_ALUOUT;
            pc_write_o  = ((opcode_i == BEQ) & zero_i) | ((opcode_i == BNE) & ~zero_i);
         end
         ST_JUMP: begin
            pc_src_o   = PC_SRC_JUMP;
            pc_write_o = 1'b1;
         end
         ST_FAULT: begin
            fault_o = 1'b1;
         end
         default: begin
            fault_o = 1'b0;
         end
      endcase
   end

   assign alu_op_o = ALU_OP_WIDTH'(alu_code);
   assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model expands each
// instruction and its memory wait pattern into the expected per-cycle state/control trace.
module tb_multicycle_control;

   localparam int WL = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode_i = 6'h00;
   logic       zero_i = 1'b0;
   logic       mem_ready_i = 1'b0;
   logic       pc_write_o;
   logic [1:0] pc_src_o;
   logic       i_or_d_o;
   logic       ir_write_o;
   logic       mem_read_o;
   logic       mem_write_o;
   logic       mem_to_reg_o;
   logic       reg_dst_o;
   logic       reg_write_o;
   logic       alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;
   logic       fault_o;

   int n_tests = 0;
   int n_fail  = 0;
   int q_state[$];
   bit q_rdy[$];
   int seen[$];

   multicycle_control #(
      .ALU_OP_WIDTH (3),
      .WAIT_LIMIT   (WL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode_i     (opcode_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .pc_write_o   (pc_write_o),
      .pc_src_o     (pc_src_o),
      .i_or_d_o     (i_or_d_o),
      .ir_write_o   (ir_write_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .mem_to_reg_o (mem_to_reg_o),
      .reg_dst_o    (reg_dst_o),
      .reg_write_o  (reg_write_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .state_o      (state_o),
      .fault_o      (fault_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [16:0] act_vec();
      return {pc_write_o, pc_src_o, i_or_d_o, ir_write_o, mem_read_o, mem_write_o,
              mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
              alu_op_o, fault_o};
   endfunction

   // Control word each state must present, straight from the per-state table.
   function automatic logic [16:0] exp_out(input int st, input logic [5:0] op,
                                           input logic rdy, input logic z);
      logic       pcw, iod, irw, mr, mw, m2r, rd, rw, sa, f;
      logic [1:0] pcs, sb;
      logic [2:0] ao;
      {pcw, iod, irw, mr, mw, m2r, rd, rw, sa, f} = '0;
      pcs = 2'b00; sb = 2'b00; ao = 3'b000;
      case (st)
         1:  begin mr = 1; sb = 2'b01; ao = 3'b100; irw = rdy; pcw = rdy; end
         2:  begin sb = 2'b11; ao = 3'b100; end
         3:  begin sa = 1; sb = 2'b10; ao = 3'b101; end
         4:  begin mr = 1; iod = 1; end
         5:  begin m2r = 1; rw = 1; end
         6:  begin mw = 1; iod = 1; end
         7:  begin sa = 1; sb = 2'b00; ao = 3'b111; end
         8:  begin rd = 1; rw = 1; end
         9:  begin
                sa = 1; sb = 2'b10;
                case (op)
                   6'h0f:   ao = 3'b001;
                   6'h0d:   ao = 3'b010;
                   6'h0c:   ao = 3'b011;
                   default: ao = 3'b100;
                endcase
             end
         10: rw = 1;
         11: begin
                sa = 1; sb = 2'b00; ao = 3'b110; pcs = 2'b01;
                pcw = (op == 6'h04) ? z : ~z;
             end
         12: begin pcs = 2'b10; pcw = 1; end
         13: f = 1;
         default: f = 0;
      endcase
      return {pcw, pcs, iod, irw, mr, mw, m2r, rd, rw, sa, sb, ao, f};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int st, input bit r, input int n);
      repeat (n) begin
         q_state.push_back(st);
         q_rdy.push_back(r);
      end
   endtask

   // A memory access waiting w cycles; more than WL waits ends in FAULT.
   task automatic mem_phase(input int st, input int w, input int tail, output bit faulted);
      if (w > WL) begin
         push(st, 1'b0, WL + 1);
         push(13, 1'b0, tail);
         faulted = 1'b1;
      end else begin
         push(st, 1'b0, w);
         push(st, 1'b1, 1);
         faulted = 1'b0;
      end
   endtask

   task automatic build(input logic [5:0] op, input int fw, input int mw, input int tail);
      bit f;
      q_state.delete();
      q_rdy.delete();
      push(0, 1'b1, 1);
      mem_phase(1, fw, tail, f);
      if (f) return;
      push(2, 1'b1, 1);
      case (op)
         6'h00: begin push(7, 1'b1, 1); push(8, 1'b1, 1); end
         6'h08, 6'h0f, 6'h0d, 6'h0c: begin push(9, 1'b1, 1); push(10, 1'b1, 1); end
         6'h23: begin
            push(3, 1'b1, 1);
            mem_phase(4, mw, tail, f);
            if (f) return;
            push(5, 1'b1, 1);
         end
         6'h2b: begin
            push(3, 1'b1, 1);
            mem_phase(6, mw, tail, f);
            if (f) return;
         end
         6'h04, 6'h05: push(11, 1'b1, 1);
         6'h02: push(12, 1'b1, 1);
         default: begin push(13, 1'b1, tail); return; end
      endcase
      push(1, 1'b0, 1);
   endtask

   task automatic run(input logic [5:0] op, input logic z, input int limit);
      seen.delete();
      @(negedge clk);
      reset = 1'b1; opcode_i = op; zero_i = z; mem_ready_i = 1'b1;
      #1;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_outputs", 32'(act_vec()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < q_state.size() && i < limit; i++) begin
         if (i > 0) @(negedge clk);
         mem_ready_i = q_rdy[i];
         #1;
         seen.push_back(int'(state_o));
         chk($sformatf("op%02h_z%0d_cyc%0d_state", op, z, i), 32'(state_o), 32'(q_state[i]));
         chk($sformatf("op%02h_z%0d_cyc%0d_ctrl", op, z, i), 32'(act_vec()),
             32'(exp_out(q_state[i], op, q_rdy[i], z)));
      end
   endtask

   function automatic int count_in(input int st);
      int c = 0;
      foreach (seen[k]) if (seen[k] == st) c++;
      return c;
   endfunction

   initial begin
      int lit[6] = '{0, 1, 2, 9, 10, 1};
      logic [5:0] iops[3] = '{6'h0f, 6'h0d, 6'h0c};
      logic [5:0] bops[2] = '{6'h04, 6'h05};

      // ADDI, zero wait states
      build(6'h08, 0, 0, 0);
      run(6'h08, 1'b0, 1000);
      chk("addi_trace_len", 32'(seen.size()), 32'd6);
      for (int k = 0; k < 6 && k < seen.size(); k++)
         chk($sformatf("addi_trace_%0d", k), 32'(seen[k]), 32'(lit[k]));
      chk("addi_wb_i_cycles", 32'(count_in(10)), 32'd1);

      build(6'h00, 0, 0, 0);
      run(6'h00, 1'b0, 1000);
      for (int k = 0; k < 3; k++) begin
         build(iops[k], 0, 0, 0);
         run(iops[k], 1'b0, 1000);
      end

      // LW with three not-ready cycles in MEM_RD
      build(6'h23, 0, 3, 0);
      run(6'h23, 1'b0, 1000);
      chk("lw_mem_rd_cycles", 32'(count_in(4)), 32'd4);
      chk("lw_mem_wb_cycles", 32'(count_in(5)), 32'd1);
      chk("lw_no_fault", 32'(fault_o), 32'd0);

      build(6'h2b, 1, 2, 0);
      run(6'h2b, 1'b0, 1000);
      chk("sw_mem_wr_cycles", 32'(count_in(6)), 32'd3);

      for (int b = 0; b < 2; b++) begin
         for (int zz = 1; zz >= 0; zz--) begin
            build(bops[b], 0, 0, 0);
            run(bops[b], 1'(zz), 1000);
            chk($sformatf("br%02h_z%0d_len", bops[b], zz), 32'(seen.size()), 32'd5);
         end
      end

      build(6'h02, 0, 0, 0);
      run(6'h02, 1'b0, 1000);
      chk("j_len", 32'(seen.size()), 32'd5);
      if (seen.size() > 4) begin
         chk("j_cycle3", 32'(seen[3]), 32'd12);
         chk("j_back_to_fetch", 32'(seen[4]), 32'd1);
      end

      // Illegal opcode traps and holds until reset
      build(6'h3f, 0, 0, 20);
      run(6'h3f, 1'b0, 1000);
      chk("illegal_fault_cycles", 32'(count_in(13)), 32'd20);
      chk("illegal_fault_o", 32'(fault_o), 32'd1);

      // Fifteen waits is the last count that still completes
      build(6'h08, WL, 0, 0);
      run(6'h08, 1'b0, 1000);
      chk("fetch_edge_cycles", 32'(count_in(1)), 32'd17);
      chk("fetch_edge_no_fault", 32'(count_in(13)), 32'd0);

      // Reset in the middle of a fetch wait, no clock edge in between
      build(6'h08, 100, 0, 0);
      run(6'h08, 1'b0, 10);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_state", 32'(state_o), 32'd0);
      chk("async_reset_mem_read", 32'(mem_read_o), 32'd0);
      chk("async_reset_outputs", 32'(act_vec()), 32'd0);

      // Fetch timeout; also shows the earlier reset cleared the wait counter
      build(6'h08, 100, 0, 5);
      run(6'h08, 1'b0, 1000);
      chk("fetch_timeout_cycles", 32'(count_in(1)), 32'd16);
      chk("fetch_timeout_fault", 32'(count_in(13)), 32'd5);

      build(6'h23, 0, 100, 4);
      run(6'h23, 1'b0, 1000);
      chk("memrd_timeout_cycles", 32'(count_in(4)), 32'd16);
      chk("memrd_timeout_fault_o", 32'(fault_o), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- An FSM sequences each instruction through fetch/decode/execute/memory/writeback.
- Adds memory ready handshaking, BEQ/BNE/J support, illegal-opcode trapping and a memory-wait timeout.
- Sits between the instruction register opcode field and the multicycle datapath (PC, IR, register file, ALU, ALUOut register, unified memory).

Parameters:
- ALU_OP_WIDTH, 3: width of alu_op_o. Codes are zero-extended when wider; values below 3 are illegal.
- WAIT_LIMIT, 15: maximum consecutive cycles a memory state may wait for mem_ready_i before FAULT. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode_i  in  6  IR[31:26], stable from DECODE onward
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current access this cycle
- pc_write_o  out  1  PC load enable
- pc_src_o  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d_o  out  1  memory address: 0 PC, 1 ALUOut
- ir_write_o  out  1  IR load enable
- mem_read_o / mem_write_o  out  1  memory strobes
- mem_to_reg_o / reg_dst_o / reg_write_o  out  1  writeback controls, same meaning as the single-cycle unit
- alu_src_a_o  out  1  0 PC, 1 rs
- alu_src_b_o  out  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2
- alu_op_o  out  ALU_OP_WIDTH  111 R-funct, 100 ADD, 110 SUB, 101 address ADD, 001 LUI, 010 OR, 011 AND
- state_o  out  4  current state code
- fault_o  out  1  sticky: illegal opcode or timeout

Behaviour:
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, WB_R 8, EXEC_I 9, WB_I 10, BRANCH 11, JUMP 12, FAULT 13.
- Reset (asynchronous): state goes to IDLE and the wait counter clears. All outputs are 0 while in IDLE.
- IDLE goes to FETCH unconditionally on the next edge.
- Outputs are a combinational decode of state, plus mem_ready_i and zero_i where noted. Unlisted outputs are 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - ir_write and pc_write are 1 only in a cycle where mem_ready_i=1.
  - Stays in FETCH until ready, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut).
  - Next state by opcode: 0x00 to EXEC_R; 0x08/0x0f/0x0d/0x0c to EXEC_I; 0x23/0x2b to MEM_ADDR; 0x04/0x05 to BRANCH; 0x02 to JUMP; any other opcode to FAULT.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111, then WB_R.
- WB_R: reg_dst=1, reg_write=1, then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op per opcode (ADDI 100, LUI 001, ORI 010, ANDI 011), then WB_I.
- WB_I: reg_write=1, reg_dst=0, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=101. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Waits for ready, then MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for ready, then FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01.
  - pc_write = (op==0x04 & zero_i) | (op==0x05 & ~zero_i).
  - Then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- Latency with zero wait states: R-type/I-ALU 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3.
- Wait counter (width $clog2(WAIT_LIMIT+1)):
  - Increments on each cycle in FETCH/MEM_RD/MEM_WR with mem_ready_i=0.
  - Clears on ready or on leaving those states.
  - If WAIT_LIMIT>0 and the counter equals WAIT_LIMIT while ready is still 0, next state is FAULT. No strobes are issued in that cycle beyond the state's normal read/write.
- FAULT: all outputs 0 except fault_o=1. Only reset exits.
- mem_ready_i outside memory states is ignored.
- Reset mid-access drops strobes immediately (asynchronous).

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode localparams (R_TYPE, ADDI, LUI, ORI, ANDI, LW, SW, BEQ, BNE, J);
  - ALU-op codes;
  - the state enum / codes;
  - pc_src and alu_src_b encodings.
- One sub-module, mem_wait_timer: counter plus timeout compare, parametrised by WAIT_LIMIT, with inputs active/ready and output expired.

Test Plan:
- Reset, then ADDI (0x08) with mem_ready_i always 1:
  - state_o sequence is 0,1,2,9,10,1.
  - alu_op_o=100 in EXEC_I, reg_write_o=1 only in WB_I.
- LW (0x23) with mem_ready_i low 3 cycles in MEM_RD:
  - MEM_RD held 4 cycles with mem_read_o=1, i_or_d_o=1.
  - MEM_WB asserts mem_to_reg_o=1, reg_write_o=1; fault_o stays 0.
- BEQ:
  - zero_i=1 gives pc_write_o=1, pc_src_o=01 in BRANCH.
  - Repeat with zero_i=0: pc_write_o=0.
  - BNE: the inverse of both cases.
- J (0x02): JUMP asserts pc_src_o=10 and pc_write_o=1, then FETCH; total 3 cycles.
- Opcode 0x3f: DECODE goes to FAULT, fault_o=1, held for 20 cycles until reset.
- WAIT_LIMIT=15 with mem_ready_i held 0 in FETCH:
  - FAULT after 16 FETCH cycles.
  - Assert reset mid-wait in a second run: state_o=0 and all strobes 0 asynchronously.
